// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO in front of the serialiser.
// All timing is derived by counting core_clk cycles per serial bit.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 40,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          core_clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned StopClks = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned BaudW    = (STOP_BITS == 2) ? $clog2(2 * CLKS_PER_BIT)
                                                        : $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BitEnd  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] StopEnd = BaudW'(StopClks - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              full, empty, push, pop;

    assign full       = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = tx_valid && !full;
    assign tx_ready   = !full;
    assign fifo_count = count_q;
    assign txd        = txd_q;
    assign busy       = (state_q != StIdle) || !empty;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BaudW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d  = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    txd_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == BitEnd) begin
                    baud_d    = '0;
                    txd_d     = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_q == BitEnd) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (baud_q == StopEnd) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge core_clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

endmodule
